isqrt_req_arbiter: RTL and testbench

Shares one pipelined isqrt unit between `N_REQ` independent requesters (formula FSMs) so that several formula blocks need only a single square-root instance. Arbitrates per cycle, issues the winner's argument to the isqrt unit, tracks each in-flight operation's owner in a tag FIFO, and routes every result back to the requester that issued it. The isqrt unit has no backpressure and returns results in issue order.

---
 rtl/isqrt_req_arbiter_if.sv | 26 ++
 rtl/isqrt_req_arbiter.sv | 119 +++++++++++
 tb/tb_isqrt_req_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/isqrt_req_arbiter_if.sv
// Request/response and isqrt-side signal bundle for isqrt_req_arbiter.
// The arbiter connects to the slave modport; requesters and the isqrt unit use master.
interface isqrt_req_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]    req_vld;
  logic [N_REQ*32-1:0] req_x;
  logic [N_REQ-1:0]    req_rdy;
  logic [N_REQ-1:0]    resp_vld;
  logic [15:0]         resp_y;
  logic                isqrt_x_vld;
  logic [31:0]         isqrt_x;
  logic                isqrt_y_vld;
  logic [15:0]         isqrt_y;
  logic                err;

  modport slave (
    input  req_vld, req_x, isqrt_y_vld, isqrt_y,
    output req_rdy, resp_vld, resp_y, isqrt_x_vld, isqrt_x, err
  );

  modport master (
    output req_vld, req_x, isqrt_y_vld, isqrt_y,
    input  req_rdy, resp_vld, resp_y, isqrt_x_vld, isqrt_x, err
  );
endinterface

// File: rtl/isqrt_req_arbiter.sv
// Shares one in-order, non-backpressured isqrt unit among N_REQ requesters via a tag FIFO.
// Define ISQRT_ARB_RR_EN for round-robin priority; otherwise lowest valid index wins.
module isqrt_req_arbiter #(
  parameter int N_REQ        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input logic                 clk,
  input logic                 rst,
  isqrt_req_arbiter_if.slave  bus
);
  localparam int PW = $clog2(MAX_INFLIGHT);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0]    fifo [MAX_INFLIGHT];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    inflight;

  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             found;
  logic             full;
  logic             empty;
  logic             accept;
  logic             pop;
  logic [N_REQ-1:0] pop_onehot;
  int unsigned      start;
  int unsigned      idx;

  logic             x_vld_q;
  logic [31:0]      x_q;
  logic [N_REQ-1:0] resp_vld_q;
  logic [15:0]      resp_y_q;
  logic             err_q;

`ifdef ISQRT_ARB_RR_EN
  logic [IW-1:0]    last_grant;
`endif

  assign full   = (inflight == CW'(MAX_INFLIGHT));
  assign empty  = (inflight == '0);
  assign accept = |grant;
  assign pop    = bus.isqrt_y_vld && !empty;

  // Both builds share one priority scan; only the starting index differs.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
`ifdef ISQRT_ARB_RR_EN
    start     = int unsigned'(last_grant) + 1;
`else
    start     = 0;
`endif
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = (start + off) % N_REQ;
      if (!found && bus.req_vld[IW'(idx)]) begin
        found     = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    if (found && !full) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    pop_onehot = '0;
    pop_onehot[fifo[rd_ptr]] = pop;
  end

  always_ff @(posedge clk) begin
    if (accept) fifo[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inflight   <= '0;
      x_vld_q    <= 1'b0;
      x_q        <= '0;
      resp_vld_q <= '0;
      resp_y_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      x_vld_q <= accept;
      if (accept) begin
        x_q    <= bus.req_x[32*grant_idx +: 32];
        wr_ptr <= wr_ptr + 1'b1;
      end
      resp_vld_q <= pop_onehot;
      if (pop) begin
        resp_y_q <= bus.isqrt_y;
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (bus.isqrt_y_vld && empty) err_q <= 1'b1;
    end
  end

`ifdef ISQRT_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_grant <= IW'(N_REQ - 1);
    else if (accept) last_grant <= grant_idx;
  end
`endif

  assign bus.req_rdy     = grant;
  assign bus.resp_vld    = resp_vld_q;
  assign bus.resp_y      = resp_y_q;
  assign bus.isqrt_x_vld = x_vld_q;
  assign bus.isqrt_x     = x_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_isqrt_req_arbiter.sv
// Directed bench for isqrt_req_arbiter with a variable-latency in-order isqrt model.
module tb_isqrt_req_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  isqrt_req_arbiter_if #(.N_REQ(2)) bus ();

  isqrt_req_arbiter #(.N_REQ(2), .MAX_INFLIGHT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat      = 4;
  logic        inj      = 1'b0;
  logic [15:0] vp;
  logic [15:0] yp [16];
  int          n_issue  = 0;
  int          n_resp   = 0;
  int          base_i;
  int          base_r;

  function automatic logic [15:0] isqrt_f(input logic [31:0] x);
    logic [31:0] r;
    r = 0;
    while (r < 65535 && (r + 1) * (r + 1) <= x) r++;
    return r[15:0];
  endfunction

  // isqrt unit: result appears lat cycles after isqrt_x_vld, cleared by the shared reset
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      vp <= '0;
      for (int k = 0; k < 16; k++) yp[k] <= '0;
    end else begin
      vp    <= {vp[14:0], bus.isqrt_x_vld};
      yp[0] <= isqrt_f(bus.isqrt_x);
      for (int k = 1; k < 16; k++) yp[k] <= yp[k-1];
    end
  end

  assign bus.isqrt_y_vld = vp[lat-1] | inj;
  assign bus.isqrt_y     = inj ? 16'hBEEF : yp[lat-1];

  always @(posedge clk) begin
    if (bus.isqrt_x_vld) n_issue++;
    if (|bus.resp_vld)   n_resp++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    bus.req_vld = '0;
    bus.req_x   = '0;
    inj         = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_rdy;

    // reset values; grant follows req_vld even in reset
    bus.req_vld = 2'b11;
    bus.req_x   = '0;
    #2;
    check("rst_rdy", bus.req_rdy, 2'b01);
    check("rst_resp_vld", bus.resp_vld, 0);
    check("rst_resp_y", bus.resp_y, 0);
    check("rst_x_vld", bus.isqrt_x_vld, 0);
    check("rst_x", bus.isqrt_x, 0);
    check("rst_err", bus.err, 0);

    // single request from requester 1, latency 4
    do_reset();
    lat = 4;
    bus.req_vld = 2'b10;
    bus.req_x[63:32] = 144;
    #1 check("t1_rdy", bus.req_rdy, 2'b10);
    tick();
    bus.req_vld = '0;
    check("t1_x_vld", bus.isqrt_x_vld, 1);
    check("t1_x", bus.isqrt_x, 144);
    tick();
    check("t1_x_vld_pulse", bus.isqrt_x_vld, 0);
    check("t1_x_hold", bus.isqrt_x, 144);
    repeat (3) tick();
    check("t1_resp_early", bus.resp_vld, 0);
    tick();
    check("t1_resp_vld", bus.resp_vld, 2'b10);
    check("t1_resp_y", bus.resp_y, 12);
    check("t1_err", bus.err, 0);
    tick();
    check("t1_resp_vld_pulse", bus.resp_vld, 0);
    check("t1_resp_y_hold", bus.resp_y, 12);

    // contention: both requesters valid for 4 cycles
    do_reset();
    lat = 4;
    bus.req_vld = 2'b11;
    bus.req_x   = {32'd25, 32'd16};
    for (int c = 0; c < 4; c++) begin
`ifdef ISQRT_ARB_RR_EN
      exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_rdy = 2'b01;
`endif
      #1 check($sformatf("t2_rdy%0d", c), bus.req_rdy, exp_rdy);
      tick();
    end
    bus.req_vld = '0;
    tick();
    check("t2_resp_early", bus.resp_vld, 0);
    tick();
    for (int c = 0; c < 4; c++) begin
`ifdef ISQRT_ARB_RR_EN
      exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("t2_y%0d", c), bus.resp_y, (c % 2 == 0) ? 4 : 5);
`else
      exp_rdy = 2'b01;
      check($sformatf("t2_y%0d", c), bus.resp_y, 4);
`endif
      check($sformatf("t2_resp%0d", c), bus.resp_vld, exp_rdy);
      tick();
    end

`ifndef ISQRT_ARB_RR_EN
    // fixed priority: requester 1 starves while requester 0 stays valid
    do_reset();
    bus.req_vld = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("t6_rdy1_%0d", c), bus.req_rdy[1], 0);
      tick();
    end
    bus.req_vld = '0;
    repeat (10) tick();
`endif

    // full FIFO: latency 8, requester 0 held valid
    do_reset();
    lat = 8;
    base_i = n_issue;
    base_r = n_resp;
    bus.req_vld = 2'b01;
    bus.req_x[31:0] = 9;
    for (int c = 0; c <= 10; c++) begin
      exp_rdy = (c < 4 || c == 10) ? 2'b01 : 2'b00;
      #1 check($sformatf("t3_rdy%0d", c), bus.req_rdy, exp_rdy);
      tick();
    end
    bus.req_vld = '0;
    repeat (20) tick();
    check("t3_issues", n_issue - base_i, 5);
    check("t3_resps", n_resp - base_r, 5);
    check("t3_err", bus.err, 0);

    // accept and return together at inflight=2
    do_reset();
    lat = 4;
    bus.req_vld = 2'b01;
    bus.req_x   = {32'd0, 32'd100};
    tick();
    bus.req_vld = 2'b10;
    bus.req_x   = {32'd49, 32'd100};
    tick();
    bus.req_vld = '0;
    repeat (3) tick();
    bus.req_vld = 2'b10;
    bus.req_x   = {32'd64, 32'd100};
    #1 check("t4_rdy", bus.req_rdy, 2'b10);
    tick();
    bus.req_vld = '0;
    check("t4_inflight", dut.inflight, 2);
    check("t4_x", bus.isqrt_x, 64);
    check("t4_resp0", bus.resp_vld, 2'b01);
    check("t4_y0", bus.resp_y, 10);
    tick();
    check("t4_resp1", bus.resp_vld, 2'b10);
    check("t4_y1", bus.resp_y, 7);
    repeat (3) tick();
    check("t4_gap", bus.resp_vld, 0);
    tick();
    check("t4_resp2", bus.resp_vld, 2'b10);
    check("t4_y2", bus.resp_y, 8);

    // spurious result with FIFO empty, then async reset with 3 in flight
    do_reset();
    lat = 8;
    inj = 1'b1;
    tick();
    inj = 1'b0;
    check("t5_no_resp", bus.resp_vld, 0);
    check("t5_err", bus.err, 1);
    repeat (3) tick();
    check("t5_err_held", bus.err, 1);
    bus.req_vld = 2'b01;
    bus.req_x   = {32'd0, 32'd200};
    repeat (3) tick();
    bus.req_vld = '0;
    check("t5_inflight3", dut.inflight, 3);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_err", bus.err, 0);
    check("t5_rst_inflight", dut.inflight, 0);
    check("t5_rst_x_vld", bus.isqrt_x_vld, 0);
    check("t5_rst_x", bus.isqrt_x, 0);
    check("t5_rst_resp_vld", bus.resp_vld, 0);
    check("t5_rst_resp_y", bus.resp_y, 0);
    @(negedge clk);
    rst = 1'b1;
    base_r = n_resp;
    repeat (15) tick();
    check("t5_no_stale", n_resp - base_r, 0);
    check("t5_err_clear", bus.err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
